fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage between the program counter and the decode stage. Drives the address of the combinational program ROM, captures each returned 16-bit instruction with its PC into a 2-entry queue, and presents them to decode over a valid/ready handshake. Supports a one-cycle redirect (jump or branch) that flushes queued instructions, and end-of-ROM handling selectable at compile time.

## Interface
- ADDR_W, 3, PC / ROM address width (8-word ROM)
- INST_W, 16, instruction width

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- run  in  1  fetch enable; 0 freezes PC and stops pushes (queue still drains)
- rom_addr  out  ADDR_W  ROM address; combinationally equal to PC register
- rom_inst  in  INST_W  ROM data; combinational function of rom_addr, same cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  INST_W  head instruction
- out_pc  out  ADDR_W  address the head instruction was fetched from
- redirect_valid  in  1  load new PC and flush queue
- redirect_addr  in  ADDR_W  redirect target
- done  out  1  end of program reached (only without wrap, see Configuration)

## Operation
- State: pc (ADDR_W), 2-entry queue of {pc, inst} with read/write pointers and 2-bit count, done flag.
- push = run & ~done & ~redirect_valid & (count<2 | pop). Captures {pc, rom_inst}; pc <= pc+1 modulo 2^ADDR_W.
- pop = out_valid & out_ready. Head transfer counts as accepted even in a redirect cycle.
- Push and pop in the same cycle allowed at any count, including full (count stays 2) and empty-bypass is NOT provided: a pushed entry is visible on out_* the next cycle.
- Redirect (highest priority): queue cleared (count 0), pc <= redirect_addr, done <= 0, no push that cycle.
- out_inst/out_pc driven from queue head; when count=0 they hold the last head value (do not care), out_valid=0.
- Instruction content is never interpreted; opcodes (e.g. 0x1/addi, 0x2/add, 0xF/out) pass through unchanged.

## Timing
- Reset values: pc=0, rom_addr=0, count=0, out_valid=0, out_inst=0, out_pc=0, done=0.
- Reset mid-operation discards queue and pc on the same edge regardless of run, redirect_valid, out_ready.
- Latency: push at edge of cycle N -> out_valid=1 in cycle N+1.
- First instruction after reset release with run=1 in cycle 0: out_valid=1, out_pc=0 in cycle 1.
- Sustained throughput: 1 instruction/cycle with run=1, out_ready=1.
- Backpressure: out_ready=0 -> queue fills in 2 cycles, then pc holds; out_inst/out_pc stable while out_valid=1 and out_ready=0.
- Redirect in cycle N: out_valid=0 in N+1; rom_addr=redirect_addr in N+1; target instruction valid in N+2.
- Redirect with run=0: pc loaded, queue flushed, no fetch until run=1.

## Configuration
- FETCH_WRAP_EN defined: pc wraps 7 -> 0 and fetch continues indefinitely; done tied 0.
- FETCH_WRAP_EN undefined: push from pc=2^ADDR_W-1 sets done=1 and pc holds at 7; no further pushes until redirect or reset; queue still drains; done clears on redirect or reset.

## Test plan
- ROM {0x1220,0x140A,0x2281,0xF200,0xF200,...}, run=1, out_ready=1 after reset -> cycles 1..4 emit (pc0,0x1220),(1,0x140A),(2,0x2281),(3,0xF200), one per cycle.
- out_ready=0 from cycle 1 for 4 cycles -> count saturates at 2, rom_addr holds at 2, out_inst stays 0x1220; release -> 0x140A, 0x2281 follow with no loss or duplication.
- Redirect to 1 while head is pc3 with out_ready=1 -> pc3 accepted, next cycle out_valid=0, following cycle (pc1,0x140A).
- Run to address 7: with FETCH_WRAP_EN next out_pc=0 after 7; without it done=1 after pc7 push, no pc0 output, redirect to 0 clears done and resumes at 0x1220.
- Assert rst_n=0 with queue full and redirect_valid=1 -> next cycle out_valid=0, rom_addr=0, done=0, out_inst=0.
- run toggled 1,0,1 each cycle with out_ready=1 -> outputs pc0,pc1,... in order with one-cycle gaps, no skipped addresses.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the ROM address from the PC, queues {pc, inst} in a 2-entry FIFO, hands off to decode.
// Compile-time option FETCH_WRAP_EN: PC wraps at end of ROM instead of stopping with done=1.
module fetch_unit #(
  parameter int ADDR_W = 3,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              done
);

  // At the last ROM word the PC either wraps or parks, depending on build.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
`ifdef FETCH_WRAP_EN
    return pc + ADDR_W'(1);
`else
    return (&pc) ? pc : pc + ADDR_W'(1);
`endif
  endfunction

  logic [ADDR_W-1:0] pc_p0;
  logic [INST_W-1:0] q_inst_p1 [2];
  logic [ADDR_W-1:0] q_pc_p1   [2];
  logic              wr_ptr_p1;
  logic              rd_ptr_p1;
  logic [1:0]        count_p1;
  logic [1:0]        count_nxt;
  logic              vld_p1;
  logic              push;
  logic              pop;

  assign vld_p1    = (count_p1 != 2'd0);
  assign out_valid = vld_p1;
  assign out_inst  = q_inst_p1[rd_ptr_p1];
  assign out_pc    = q_pc_p1[rd_ptr_p1];
  assign rom_addr  = pc_p0;

  assign pop  = vld_p1 & out_ready;
  assign push = run & ~done & ~redirect_valid & ((count_p1 != 2'd2) | pop);

  always_comb begin
    count_nxt = count_p1;
    if (push && !pop)
      count_nxt = count_p1 + 2'd1;
    else if (!push && pop)
      count_nxt = count_p1 - 2'd1;
  end

  // ---- stage p0: program counter / ROM address ----
  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_p0 <= '0;
    else if (redirect_valid)
      pc_p0 <= redirect_addr;
    else if (push)
      pc_p0 <= pc_inc(pc_p0);
  end

  // ---- stage p1: instruction queue (data cleared on reset so the head reads 0) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      count_p1  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_inst_p1[i] <= '0;
        q_pc_p1[i]   <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      count_p1  <= 2'd0;
    end else begin
      count_p1 <= count_nxt;
      if (pop)
        rd_ptr_p1 <= ~rd_ptr_p1;
      if (push) begin
        q_inst_p1[wr_ptr_p1] <= rom_inst;
        q_pc_p1[wr_ptr_p1]   <= pc_p0;
        wr_ptr_p1            <= ~wr_ptr_p1;
      end
    end
  end

`ifdef FETCH_WRAP_EN
  assign done = 1'b0;
`else
  logic done_p0;

  always_ff @(posedge clk) begin
    if (!rst_n)
      done_p0 <= 1'b0;
    else if (redirect_valid)
      done_p0 <= 1'b0;
    else if (push && (&pc_p0))
      done_p0 <= 1'b1;
  end

  assign done = done_p0;
`endif

endmodule
